hazard_unit: RTL and testbench
==============================

# hazard_unit

Hazard detection and forwarding controller for the 5-stage pipelined LEGv8 core. It keeps its own shadow copy of the EX, MEM and WB stage occupancy: valid flag, destination register and source registers. From this it generates:
- PC/IF-ID stall
- per-stage flush
- ALU operand forwarding selects

It sits beside the controller and datapath, fed from ID-stage decode fields, and lets the core run dependent instruction streams without software NOPs.

## Interface
- REG_AW, 5, register address width
- ZERO_REG, 31, register index (XZR) that never creates a dependency
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_AW  first source (Rn)
- id_rs2  in  REG_AW  second source (Rm or Rt, post-reg2loc mux)
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  REG_AW  destination
- id_regWrite  in  1  instruction writes rd
- id_memRead  in  1  instruction is a load
- branch_taken  in  1  instruction now in MEM is a taken branch
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  zero the named pipeline register next edge
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- stall_cycles, flush_events  out  CNT_W  saturating performance counters

## Operation
- Shadow entries ex_q, mem_q, wb_q each hold {valid, rd, regWrite, memRead, rs1, rs2, use_rs1, use_rs2}.
- A writer entry is one with valid, regWrite and rd≠ZERO_REG.
- Each edge:
  - wb_q ← mem_q.
  - mem_q ← bubble if branch_taken, else ex_q.
  - ex_q ← bubble if branch_taken, stall or !id_valid; otherwise ex_q ← ID fields.
- Forwarding for fwd_a (fwd_b identical, using rs2 and use_rs2):
  - 10 if ex_q.use_rs1 and mem_q is a writer with mem_q.rd = ex_q.rs1.
  - Else 01 if the same test passes against wb_q.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
- Stall is raised only when id_valid and a used ID source matches the rd of a writer:
  - Load-use: ex_q is a writer with memRead.
- Flush:
  - branch_taken asserts all three flush outputs in the same cycle.
  - branch_taken forces stall to 0 because the ID instruction is discarded anyway.
- Counters:
  - stall_cycles increments on each cycle with stall=1.
  - flush_events increments on each cycle with branch_taken=1.
  - Both hold at all-ones and do not wrap.
- The register file is write-first. A WB-stage producer is visible to an ID read in the same cycle and never causes a stall.

## Timing
- stall, flush_* and fwd_* are combinational from current shadow state and ID/branch inputs. They are valid before the same clk edge that consumes them.
- Shadow state and counters update on the rising clk edge.
- Load-use costs exactly 1 bubble cycle (FORWARDING_EN defined).
- Branch taken costs 3 squashed instructions.
- Simultaneous branch_taken and load-use hazard: flush wins, stall=0, stall_cycles does not increment.
- Stall with id_valid=0 is impossible by construction; stall is 0.
- Reset, including mid-stall or mid-flush:
  - All shadow entries invalid next edge.
  - stall=0, flush_*=0, fwd_a=fwd_b=00.
  - Counters 0.
  - No hazard persists across reset.

## Configuration
- FORWARDING_EN defined:
  - Forwarding as above.
  - Stall only on load-use.
- FORWARDING_EN undefined:
  - fwd_a=fwd_b=00 constantly.
  - Stall whenever a used ID source matches a writer in ex_q or mem_q, regardless of memRead.
  - A dependent instruction directly behind a producer costs 2 bubbles; one instruction apart costs 1 bubble.
  - Forwarding comparator logic is not synthesised.

## Test plan
- Forwarding from EX/MEM: ADD X1,X2,X3 then SUB X4,X1,X5 -> no stall; fwd_a=10 in the cycle SUB is in EX.
- Forwarding from MEM/WB: ADD X1 then independent instruction then ORR X6,X7,X1 -> fwd_b=01, fwd_a=00, no stall.
- Load-use: LDUR X9,[X10] then ADD X11,X9,X9 -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=01; stall_cycles=1.
- XZR dependency: writer with rd=31 followed by reader of X31 -> stall=0, fwd=00.
- Branch collision: branch_taken=1 while a load-use hazard is present -> all three flushes=1, stall=0, stall_cycles unchanged, flush_events+1.
- Without FORWARDING_EN: ADD X1 then SUB using X1 -> stall=1 for 2 cycles, fwd=00 throughout. Assert reset during the second stall cycle -> stall=0 next cycle, counters 0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// ID-stage decode fields, branch resolution and the hazard controls returned to the core.
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regWrite;
  logic              id_memRead;
  logic              branch_taken;
  logic              stall;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regWrite, id_memRead, branch_taken,
    input  stall, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regWrite, id_memRead, branch_taken,
    output stall, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_unit.sv
// LEGv8 hazard detection / forwarding controller with EX/MEM/WB shadow occupancy.
// Build option: define FORWARDING_EN to enable operand forwarding (stall only on load-use).
module hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hif
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  function automatic logic is_writer(input entry_t e);
    return e.valid & e.reg_write & (e.rd != ZERO_ADDR);
  endfunction

  function automatic logic hits(input entry_t e, input logic use_src, input logic [REG_AW-1:0] src);
    return use_src & is_writer(e) & (e.rd == src);
  endfunction

  entry_t           ex_r, mem_r, wb_r;
  entry_t           id_s, ex_next_s, mem_next_s;
  logic             raw_s;
  logic             stall_s;
  logic             flush_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             unused_s;

  // Pack the ID decode fields into a shadow entry.
  always_comb begin
    id_s           = BUBBLE;
    id_s.valid     = hif.id_valid;
    id_s.rd        = hif.id_rd;
    id_s.reg_write = hif.id_regWrite;
    id_s.mem_read  = hif.id_memRead;
    id_s.rs1       = hif.id_rs1;
    id_s.rs2       = hif.id_rs2;
    id_s.use_rs1   = hif.id_use_rs1;
    id_s.use_rs2   = hif.id_use_rs2;
  end

  // Dependency of the ID instruction on producers not yet visible through the register file.
  always_comb begin
    raw_s = 1'b0;
`ifdef FORWARDING_EN
    raw_s = ex_r.mem_read & (hits(ex_r, hif.id_use_rs1, hif.id_rs1) |
                             hits(ex_r, hif.id_use_rs2, hif.id_rs2));
`else
    raw_s = hits(ex_r,  hif.id_use_rs1, hif.id_rs1) | hits(ex_r,  hif.id_use_rs2, hif.id_rs2) |
            hits(mem_r, hif.id_use_rs1, hif.id_rs1) | hits(mem_r, hif.id_use_rs2, hif.id_rs2);
`endif
  end

  // Stall, flush and forwarding selects; a taken branch discards ID so it overrides stall.
  always_comb begin
    stall_s = 1'b0;
    flush_s = 1'b0;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (reset) begin
      stall_s = 1'b0;
      flush_s = 1'b0;
    end else begin
      flush_s = hif.branch_taken;
      if (hif.id_valid && !hif.branch_taken) begin
        stall_s = raw_s;
      end else begin
        stall_s = 1'b0;
      end
`ifdef FORWARDING_EN
      // EX/MEM result is younger than MEM/WB, so it is checked first.
      if (hits(mem_r, ex_r.use_rs1, ex_r.rs1)) begin
        fwd_a_s = 2'b10;
      end else if (hits(wb_r, ex_r.use_rs1, ex_r.rs1)) begin
        fwd_a_s = 2'b01;
      end else begin
        fwd_a_s = 2'b00;
      end
      if (hits(mem_r, ex_r.use_rs2, ex_r.rs2)) begin
        fwd_b_s = 2'b10;
      end else if (hits(wb_r, ex_r.use_rs2, ex_r.rs2)) begin
        fwd_b_s = 2'b01;
      end else begin
        fwd_b_s = 2'b00;
      end
`endif
    end
  end

  // Next shadow contents: bubbles enter on branch squash, stall or an empty ID slot.
  always_comb begin
    mem_next_s = ex_r;
    ex_next_s  = id_s;
    if (hif.branch_taken) begin
      mem_next_s = BUBBLE;
      ex_next_s  = BUBBLE;
    end else if (stall_s || !hif.id_valid) begin
      ex_next_s  = BUBBLE;
    end else begin
      ex_next_s  = id_s;
    end
  end

  // Shadow pipeline and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r        <= BUBBLE;
      mem_r       <= BUBBLE;
      wb_r        <= BUBBLE;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ex_r  <= ex_next_s;
      mem_r <= mem_next_s;
      wb_r  <= mem_r;
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  // Some shadow fields only matter in one build configuration.
  assign unused_s = ^{ex_r, mem_r, wb_r};

  assign hif.stall        = stall_s;
  assign hif.flush_if_id  = flush_s;
  assign hif.flush_id_ex  = flush_s;
  assign hif.flush_ex_mem = flush_s;
  assign hif.fwd_a        = fwd_a_s;
  assign hif.fwd_b        = fwd_b_s;
  assign hif.stall_cycles = stall_cnt_r;
  assign hif.flush_events = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed LEGv8 sequences plus randomized traffic.
module tb_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(AW), .CNT_W(CW)) hif ();
  hazard_unit #(.REG_AW(AW), .ZERO_REG(31), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hif(hif));

  typedef struct {
    bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
  } instr_t;

  instr_t pipe [3];
  instr_t prev_id;
  bit     prev_br, prev_rst, prev_stall, last_stall;
  int     stall_cnt, flush_cnt;
  logic [15:0] exp_q [$];
  int     checks = 0;
  int     passes = 0;

  function automatic instr_t nop();
    instr_t n;
    n = '{v:1'b0, rd:0, wr:1'b0, ld:1'b0, rs1:0, rs2:0, u1:1'b0, u2:1'b0};
    return n;
  endfunction

  function automatic instr_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit wr, bit ld);
    instr_t n;
    n = '{v:1'b1, rd:rd, wr:wr, ld:ld, rs1:rs1, rs2:rs2, u1:u1, u2:u2};
    return n;
  endfunction

  // does stage entry p produce register src for a reader that actually uses it
  function automatic bit produces(instr_t p, int src, bit u);
    return u && p.v && p.wr && (p.rd != 31) && (p.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(int src, bit u);
`ifdef FORWARDING_EN
    for (int k = 1; k <= 2; k++)
      if (produces(pipe[k], src, u)) return (k == 1) ? 2'b10 : 2'b01;
`endif
    return 2'b00;
  endfunction

  // hazard window: forwarding covers everything but a load right ahead; without it EX and MEM both block
  function automatic bit needs_stall(instr_t id);
    int depth;
    bit fwd;
`ifdef FORWARDING_EN
    fwd = 1'b1; depth = 1;
`else
    fwd = 1'b0; depth = 2;
`endif
    if (!id.v) return 1'b0;
    for (int k = 0; k < depth; k++)
      if ((produces(pipe[k], id.rs1, id.u1) || produces(pipe[k], id.rs2, id.u2)) && (!fwd || pipe[k].ld))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_advance();
    if (prev_rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = nop();
      stall_cnt = 0;
      flush_cnt = 0;
    end else begin
      if (prev_stall && stall_cnt < SAT) stall_cnt++;
      if (prev_br && flush_cnt < SAT) flush_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = prev_br ? nop() : pipe[0];
      pipe[0] = (prev_br || prev_stall || !prev_id.v) ? nop() : prev_id;
    end
  endtask

  task automatic step(input instr_t id, input bit br, input bit rst);
    bit st;
    logic [1:0] fa, fb;
    @(posedge clk);
    model_advance();
    #1;
    reset            = rst;
    hif.id_valid     = id.v;
    hif.id_rd        = AW'(id.rd);
    hif.id_rs1       = AW'(id.rs1);
    hif.id_rs2       = AW'(id.rs2);
    hif.id_use_rs1   = id.u1;
    hif.id_use_rs2   = id.u2;
    hif.id_regWrite  = id.wr;
    hif.id_memRead   = id.ld;
    hif.branch_taken = br;
    st = !rst && !br && needs_stall(id);
    fa = rst ? 2'b00 : fwd_sel(pipe[0].rs1, pipe[0].u1);
    fb = rst ? 2'b00 : fwd_sel(pipe[0].rs2, pipe[0].u2);
    exp_q.push_back({st, {3{!rst && br}}, fa, fb, CW'(stall_cnt), CW'(flush_cnt)});
    prev_id = id; prev_br = br; prev_rst = rst; prev_stall = st; last_stall = st;
  endtask

  // issue one instruction, re-presenting it while held by a stall
  task automatic issue(input instr_t id);
    int n;
    n = 0;
    step(id, 1'b0, 1'b0);
    while (last_stall && n < 4) begin
      step(id, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic do_reset();
    step(nop(), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(nop(), 1'b0, 1'b0);
  endtask

  task automatic direct(input string name, input int act, input int req);
    @(negedge clk);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // monitor: every cycle's outputs are compared with the queued expectation
  initial begin
    logic [15:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {hif.stall, hif.flush_if_id, hif.flush_id_ex, hif.flush_ex_mem,
             hif.fwd_a, hif.fwd_b, hif.stall_cycles, hif.flush_events};
        checks++;
        if (a === e) passes++;
        else $display("FAIL outputs @%0t: got st=%b fl=%b fa=%b fb=%b sc=%0d fe=%0d, expected st=%b fl=%b fa=%b fb=%b sc=%0d fe=%0d",
                      $time, a[15], a[14:12], a[11:10], a[9:8], a[7:4], a[3:0],
                      e[15], e[14:12], e[11:10], e[9:8], e[7:4], e[3:0]);
      end
    end
  end

  initial begin
    int r;
    instr_t id;
    reset = 1'b1;
    hif.id_valid = 1'b0; hif.id_rd = '0; hif.id_rs1 = '0; hif.id_rs2 = '0;
    hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0; hif.id_regWrite = 1'b0;
    hif.id_memRead = 1'b0; hif.branch_taken = 1'b0;
    prev_rst = 1'b1; prev_br = 1'b0; prev_stall = 1'b0; last_stall = 1'b0;
    prev_id = nop(); stall_cnt = 0; flush_cnt = 0;
    for (int k = 0; k < 3; k++) pipe[k] = nop();

    do_reset();
    direct("reset_stall", int'(hif.stall), 0);
    direct("reset_fwd_a", int'(hif.fwd_a), 0);

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    do_reset();
    issue(mk(1, 2, 3, 1, 1, 1, 0));
    issue(mk(4, 1, 5, 1, 1, 1, 0));
    drain();
`ifdef FORWARDING_EN
    direct("exmem_fwd_stalls", int'(hif.stall_cycles), 0);
`else
    direct("nofwd_adjacent_stalls", int'(hif.stall_cycles), 2);
`endif

    // ADD X1 ; AND X8,X2,X3 ; ORR X6,X7,X1
    do_reset();
    issue(mk(1, 2, 3, 1, 1, 1, 0));
    issue(mk(8, 2, 3, 1, 1, 1, 0));
    issue(mk(6, 7, 1, 1, 1, 1, 0));
    drain();
`ifdef FORWARDING_EN
    direct("memwb_fwd_stalls", int'(hif.stall_cycles), 0);
`else
    direct("nofwd_gap1_stalls", int'(hif.stall_cycles), 1);
`endif

    // LDUR X9,[X10] ; ADD X11,X9,X9
    do_reset();
    issue(mk(9, 10, 0, 1, 0, 1, 1));
    issue(mk(11, 9, 9, 1, 1, 1, 0));
    drain();
`ifdef FORWARDING_EN
    direct("load_use_stalls", int'(hif.stall_cycles), 1);
`else
    direct("nofwd_load_use_stalls", int'(hif.stall_cycles), 2);
`endif

    // XZR writer then XZR reader
    do_reset();
    issue(mk(31, 2, 3, 1, 1, 1, 0));
    issue(mk(4, 31, 31, 1, 1, 1, 0));
    drain();
    direct("xzr_stalls", int'(hif.stall_cycles), 0);

    // branch collides with a load-use hazard
    do_reset();
    issue(mk(9, 10, 0, 1, 0, 1, 1));
    step(mk(11, 9, 9, 1, 1, 1, 0), 1'b1, 1'b0);
    drain();
    direct("collision_stalls", int'(hif.stall_cycles), 0);
    direct("collision_flushes", int'(hif.flush_events), 1);

    // reset in the middle of a dependency stall
    do_reset();
    step(mk(1, 2, 3, 1, 1, 1, 0), 1'b0, 1'b0);
    step(mk(4, 1, 5, 1, 1, 1, 0), 1'b0, 1'b0);
    step(mk(4, 1, 5, 1, 1, 1, 0), 1'b0, 1'b1);
    step(mk(4, 1, 5, 1, 1, 1, 0), 1'b0, 1'b0);
    direct("post_reset_stall_cnt", int'(hif.stall_cycles), 0);
    drain();

    // flush counter saturates
    do_reset();
    for (int i = 0; i < SAT + 5; i++) step(nop(), 1'b1, 1'b0);
    drain();
    direct("flush_saturate", int'(hif.flush_events), SAT);

    // randomized traffic over a small register pool to provoke hazards
    do_reset();
    id = nop();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r = $urandom_range(0, 4);
        id.rd  = (r == 4) ? 31 : r;
        r = $urandom_range(0, 4);
        id.rs1 = (r == 4) ? 31 : r;
        r = $urandom_range(0, 4);
        id.rs2 = (r == 4) ? 31 : r;
        id.v  = ($urandom_range(0, 7) != 0);
        id.u1 = $urandom_range(0, 1) == 1;
        id.u2 = $urandom_range(0, 1) == 1;
        id.wr = ($urandom_range(0, 3) != 0);
        id.ld = id.wr && ($urandom_range(0, 2) == 0);
      end
      step(id, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end
    drain();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
